// File: rtl/arp_tx_gen_if.sv
// arp_tx_gen_if: command side and GMII side of the ARP frame transmitter.
// The vlan_tci member exists only when ARP_TX_VLAN_EN is defined.
interface arp_tx_gen_if;
   logic        tx_req;
   logic        tx_ready;
   logic [1:0]  tx_op;
   logic [47:0] local_mac;
   logic [31:0] local_ip;
   logic [47:0] des_mac;
   logic [31:0] des_ip;
`ifdef ARP_TX_VLAN_EN
   logic [15:0] vlan_tci;
`endif
   logic        tx_busy;
   logic        tx_done;
   logic        gmii_tx_en;
   logic [7:0]  gmii_txd;

   // Control logic side: issues commands, observes status and GMII.
   modport master (
`ifdef ARP_TX_VLAN_EN
      output vlan_tci,
`endif
      output tx_req, tx_op, local_mac, local_ip, des_mac, des_ip,
      input  tx_ready, tx_busy, tx_done, gmii_tx_en, gmii_txd
   );

   // Transmitter side.
   modport slave (
`ifdef ARP_TX_VLAN_EN
      input  vlan_tci,
`endif
      input  tx_req, tx_op, local_mac, local_ip, des_mac, des_ip,
      output tx_ready, tx_busy, tx_done, gmii_tx_en, gmii_txd
   );
endinterface

// File: rtl/arp_tx_gen.sv
// arp_tx_gen: ARP request/reply/gratuitous frame generator, GMII 8-bit,
// one byte per clock. Frame = preamble + SFD, Ethernet header, 28-byte ARP
// body, zero pad up to MIN_PAYLOAD, CRC-32 FCS, then an enforced gap.
// Optional feature: define ARP_TX_VLAN_EN to add an 802.1Q tag
// (0x8100 + vlan_tci) between the source MAC and the EtherType.
module arp_tx_gen #(
   parameter int PREAMBLE_LEN = 7,
   parameter int MIN_PAYLOAD  = 46,
   parameter int IFG_CYCLES   = 12
) (
   input  logic        clk,
   input  logic        rst_n,
   arp_tx_gen_if.slave bus
);

   localparam int ARP_LEN = 28;
`ifdef ARP_TX_VLAN_EN
   localparam int HDR_LEN = 18;
`else
   localparam int HDR_LEN = 14;
`endif
   localparam int HA_LEN  = HDR_LEN + ARP_LEN;
   localparam int HA_BITS = HA_LEN * 8;
   localparam int PAY_EFF = (MIN_PAYLOAD < ARP_LEN) ? ARP_LEN : MIN_PAYLOAD;

   localparam logic [15:0] PRE_LAST = 16'(PREAMBLE_LEN);
   localparam logic [15:0] HDR_LAST = 16'(HDR_LEN - 1);
   localparam logic [15:0] HDR_BASE = 16'(HDR_LEN);
   localparam logic [15:0] ARP_LAST = 16'(ARP_LEN - 1);
   localparam logic [15:0] PAD_CNT  = 16'(PAY_EFF - ARP_LEN);
   localparam logic [15:0] IFG_LAST = 16'(IFG_CYCLES - 1);
   localparam logic [47:0] BCAST    = 48'hFFFF_FFFF_FFFF;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_PREAMBLE = 3'd1,
      ST_HEADER   = 3'd2,
      ST_ARP      = 3'd3,
      ST_PAD      = 3'd4,
      ST_FCS      = 3'd5,
      ST_IFG      = 3'd6
   } state_t;

   // state_r/cnt_r describe the byte currently on gmii_txd.
   state_t      state_r;
   logic [15:0] cnt_r;

   // Command fields latched at acceptance.
   logic [47:0] dst_mac_r;
   logic [47:0] src_mac_r;
   logic [15:0] oper_r;
   logic [31:0] spa_r;
   logic [47:0] tha_r;
   logic [31:0] tpa_r;
`ifdef ARP_TX_VLAN_EN
   logic [15:0] vlan_r;
`endif

   logic [31:0] crc_r;
   logic [31:0] crc_next_s;
   logic [HA_BITS-1:0] ha_vec_s;

   logic        tx_ready_r;
   logic        tx_busy_r;
   logic        tx_done_r;
   logic        gmii_tx_en_r;
   logic [7:0]  gmii_txd_r;

   // One byte of reflected CRC-32 (poly 0xEDB88320), LSB bit first.
   function automatic logic [31:0] crc32_byte(input logic [31:0] crc,
                                              input logic [7:0]  d);
      logic [31:0] c;
      c = crc;
      for (int i = 0; i < 8; i++) begin
         if (c[0] ^ d[i]) begin
            c = {1'b0, c[31:1]} ^ 32'hEDB8_8320;
         end else begin
            c = {1'b0, c[31:1]};
         end
      end
      return c;
   endfunction

   // Byte pos (0 = first) of the header+ARP image, MSB byte first.
   function automatic logic [7:0] ha_byte(input logic [HA_BITS-1:0] vec,
                                          input logic [15:0]        pos);
      logic [HA_BITS-1:0] sh;
      sh = vec << {pos, 3'b000};
      return sh[HA_BITS-1 -: 8];
   endfunction

   // FCS byte k: complemented CRC register, least significant byte first.
   function automatic logic [7:0] fcs_byte(input logic [31:0] crc,
                                           input logic [1:0]  k);
      logic [7:0] b;
      case (k)
         2'd0:    b = ~crc[7:0];
         2'd1:    b = ~crc[15:8];
         2'd2:    b = ~crc[23:16];
         2'd3:    b = ~crc[31:24];
         default: b = 8'h00;
      endcase
      return b;
   endfunction

   // Header and ARP body image built from the latched command.
   assign ha_vec_s = {
      dst_mac_r, src_mac_r,
`ifdef ARP_TX_VLAN_EN
      8'h81, 8'h00, vlan_r,
`endif
      16'h0806,
      16'h0001, 16'h0800, 8'h06, 8'h04, oper_r,
      src_mac_r, spa_r, tha_r, tpa_r
   };

   // CRC including the byte now on the wire when it lies in dst..pad;
   // outside that range the register simply holds.
   always_comb begin
      crc_next_s = crc_r;
      if ((state_r == ST_HEADER) || (state_r == ST_ARP) || (state_r == ST_PAD)) begin
         crc_next_s = crc32_byte(crc_r, gmii_txd_r);
      end else begin
         crc_next_s = crc_r;
      end
   end

   // Frame sequencer: every output is registered and describes the next byte.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= ST_IDLE;
         cnt_r        <= 16'd0;
         dst_mac_r    <= 48'd0;
         src_mac_r    <= 48'd0;
         oper_r       <= 16'd0;
         spa_r        <= 32'd0;
         tha_r        <= 48'd0;
         tpa_r        <= 32'd0;
`ifdef ARP_TX_VLAN_EN
         vlan_r       <= 16'd0;
`endif
         crc_r        <= 32'hFFFF_FFFF;
         tx_ready_r   <= 1'b1;
         tx_busy_r    <= 1'b0;
         tx_done_r    <= 1'b0;
         gmii_tx_en_r <= 1'b0;
         gmii_txd_r   <= 8'h00;
      end else begin
         tx_done_r <= 1'b0;
         crc_r     <= crc_next_s;
         case (state_r)
            ST_IDLE: begin
               if (bus.tx_req && tx_ready_r) begin
                  src_mac_r <= bus.local_mac;
                  spa_r     <= bus.local_ip;
`ifdef ARP_TX_VLAN_EN
                  vlan_r    <= bus.vlan_tci;
`endif
                  crc_r     <= 32'hFFFF_FFFF;
                  case (bus.tx_op)
                     2'd0: begin
                        dst_mac_r <= BCAST;
                        oper_r    <= 16'h0001;
                        tha_r     <= 48'd0;
                        tpa_r     <= bus.des_ip;
                     end
                     2'd1: begin
                        dst_mac_r <= bus.des_mac;
                        oper_r    <= 16'h0002;
                        tha_r     <= bus.des_mac;
                        tpa_r     <= bus.des_ip;
                     end
                     2'd2: begin
                        dst_mac_r <= BCAST;
                        oper_r    <= 16'h0001;
                        tha_r     <= 48'd0;
                        tpa_r     <= bus.local_ip;
                     end
                     default: begin
                        dst_mac_r <= dst_mac_r;
                     end
                  endcase
                  if (bus.tx_op == 2'd3) begin
                     // Reserved opcode: acknowledge only, stay ready.
                     tx_done_r <= 1'b1;
                  end else begin
                     state_r      <= ST_PREAMBLE;
                     cnt_r        <= 16'd0;
                     gmii_tx_en_r <= 1'b1;
                     gmii_txd_r   <= 8'h55;
                     tx_ready_r   <= 1'b0;
                     tx_busy_r    <= 1'b1;
                  end
               end
            end

            ST_PREAMBLE: begin
               if (cnt_r == PRE_LAST) begin
                  state_r    <= ST_HEADER;
                  cnt_r      <= 16'd0;
                  gmii_txd_r <= ha_byte(ha_vec_s, 16'd0);
               end else begin
                  cnt_r      <= cnt_r + 16'd1;
                  gmii_txd_r <= ((cnt_r + 16'd1) == PRE_LAST) ? 8'hD5 : 8'h55;
               end
            end

            ST_HEADER: begin
               if (cnt_r == HDR_LAST) begin
                  state_r    <= ST_ARP;
                  cnt_r      <= 16'd0;
                  gmii_txd_r <= ha_byte(ha_vec_s, HDR_BASE);
               end else begin
                  cnt_r      <= cnt_r + 16'd1;
                  gmii_txd_r <= ha_byte(ha_vec_s, cnt_r + 16'd1);
               end
            end

            ST_ARP: begin
               if (cnt_r == ARP_LAST) begin
                  cnt_r <= 16'd0;
                  if (PAD_CNT == 16'd0) begin
                     state_r    <= ST_FCS;
                     gmii_txd_r <= fcs_byte(crc_next_s, 2'd0);
                  end else begin
                     state_r    <= ST_PAD;
                     gmii_txd_r <= 8'h00;
                  end
               end else begin
                  cnt_r      <= cnt_r + 16'd1;
                  gmii_txd_r <= ha_byte(ha_vec_s, HDR_BASE + cnt_r + 16'd1);
               end
            end

            ST_PAD: begin
               if ((cnt_r + 16'd1) == PAD_CNT) begin
                  state_r    <= ST_FCS;
                  cnt_r      <= 16'd0;
                  gmii_txd_r <= fcs_byte(crc_next_s, 2'd0);
               end else begin
                  cnt_r      <= cnt_r + 16'd1;
                  gmii_txd_r <= 8'h00;
               end
            end

            ST_FCS: begin
               if (cnt_r == 16'd3) begin
                  gmii_tx_en_r <= 1'b0;
                  gmii_txd_r   <= 8'h00;
                  tx_done_r    <= 1'b1;
                  cnt_r        <= 16'd0;
                  // The cycle in which tx_ready is back is the last gap
                  // cycle, so a one-cycle gap returns straight to idle.
                  if (IFG_LAST == 16'd0) begin
                     state_r    <= ST_IDLE;
                     tx_ready_r <= 1'b1;
                     tx_busy_r  <= 1'b0;
                  end else begin
                     state_r    <= ST_IFG;
                  end
               end else begin
                  cnt_r      <= cnt_r + 16'd1;
                  gmii_txd_r <= fcs_byte(crc_next_s, cnt_r[1:0] + 2'd1);
               end
            end

            ST_IFG: begin
               if ((cnt_r + 16'd1) == IFG_LAST) begin
                  state_r    <= ST_IDLE;
                  cnt_r      <= 16'd0;
                  tx_ready_r <= 1'b1;
                  tx_busy_r  <= 1'b0;
               end else begin
                  cnt_r      <= cnt_r + 16'd1;
               end
            end

            default: begin
               state_r      <= ST_IDLE;
               cnt_r        <= 16'd0;
               gmii_tx_en_r <= 1'b0;
               gmii_txd_r   <= 8'h00;
               tx_ready_r   <= 1'b1;
               tx_busy_r    <= 1'b0;
            end
         endcase
      end
   end

   assign bus.tx_ready   = tx_ready_r;
   assign bus.tx_busy    = tx_busy_r;
   assign bus.tx_done    = tx_done_r;
   assign bus.gmii_tx_en = gmii_tx_en_r;
   assign bus.gmii_txd   = gmii_txd_r;

endmodule

// File: tb/tb_arp_tx_gen.sv
// tb_arp_tx_gen: directed bench for arp_tx_gen at default parameters.
// Frames are captured byte by byte and compared with hand-built images;
// the FCS is checked through the well-known CRC-32 residue.
module tb_arp_tx_gen;

   localparam int PRE_BYTES = 8;
`ifdef ARP_TX_VLAN_EN
   localparam int FRAME_EN = 76;
`else
   localparam int FRAME_EN = 72;
`endif
   localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;
   localparam logic [47:0] MAC   = 48'h0011_2233_4455;

   logic clk;
   logic rst_n;
   arp_tx_gen_if bus();

   arp_tx_gen #(
      .PREAMBLE_LEN(7),
      .MIN_PAYLOAD (46),
      .IFG_CYCLES  (12)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   int vectors = 0;
   int miscompares = 0;
   logic [7:0] got_q[$];
   logic [7:0] exp_q[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected image: preamble, SFD, header, ARP body, pad (FCS excluded).
   function automatic void build_exp(input logic [47:0] dst, input logic [15:0] oper,
                                     input logic [31:0] spa, input logic [47:0] tha,
                                     input logic [31:0] tpa, input logic [15:0] tci);
      exp_q.delete();
      repeat (7) exp_q.push_back(8'h55);
      exp_q.push_back(8'hD5);
      for (int i = 5; i >= 0; i--) exp_q.push_back(dst[i*8 +: 8]);
      for (int i = 5; i >= 0; i--) exp_q.push_back(MAC[i*8 +: 8]);
`ifdef ARP_TX_VLAN_EN
      exp_q.push_back(8'h81); exp_q.push_back(8'h00);
      exp_q.push_back(tci[15:8]); exp_q.push_back(tci[7:0]);
`else
      if (tci != 16'h0000) exp_q.push_back(8'hEE);
`endif
      exp_q.push_back(8'h08); exp_q.push_back(8'h06);
      exp_q.push_back(8'h00); exp_q.push_back(8'h01);
      exp_q.push_back(8'h08); exp_q.push_back(8'h00);
      exp_q.push_back(8'h06); exp_q.push_back(8'h04);
      exp_q.push_back(oper[15:8]); exp_q.push_back(oper[7:0]);
      for (int i = 5; i >= 0; i--) exp_q.push_back(MAC[i*8 +: 8]);
      for (int i = 3; i >= 0; i--) exp_q.push_back(spa[i*8 +: 8]);
      for (int i = 5; i >= 0; i--) exp_q.push_back(tha[i*8 +: 8]);
      for (int i = 3; i >= 0; i--) exp_q.push_back(tpa[i*8 +: 8]);
      repeat (18) exp_q.push_back(8'h00);
   endfunction

   // Index of the first captured byte differing from the image, or -1.
   function automatic int first_diff();
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i >= got_q.size()) return i;
         if (got_q[i] !== exp_q[i]) return i;
      end
      return -1;
   endfunction

   // CRC-32 over dst..FCS, bit-reversed to the usual 0xC704DD7B form.
   function automatic logic [31:0] residue();
      logic [31:0] r;
      logic [31:0] rev;
      r = 32'hFFFF_FFFF;
      for (int i = PRE_BYTES; i < got_q.size(); i++) begin
         for (int b = 0; b < 8; b++) begin
            if (r[0] ^ got_q[i][b]) r = {1'b0, r[31:1]} ^ 32'hEDB8_8320;
            else                    r = {1'b0, r[31:1]};
         end
      end
      for (int b = 0; b < 32; b++) rev[b] = r[31-b];
      return rev;
   endfunction

   // Record bytes while gmii_tx_en is high; returns at first low negedge.
   task automatic capture(output int n);
      int t;
      n = 0;
      t = 0;
      got_q.delete();
      while (!bus.gmii_tx_en && t < 200) begin @(negedge clk); t++; end
      while (bus.gmii_tx_en && n < 2000) begin
         got_q.push_back(bus.gmii_txd);
         n++;
         @(negedge clk);
      end
   endtask

   // Wait for tx_ready, present a one-cycle command; returns one cycle later.
   task automatic issue(input logic [1:0] op);
      int t;
      @(negedge clk);
      t = 0;
      while (!bus.tx_ready && t < 200) begin @(negedge clk); t++; end
      if (t >= 200) begin
         vectors++; miscompares++;
         $display("FAIL issue_timeout: tx_ready still %b after %0d cycles, need 1", bus.tx_ready, t);
      end
      bus.tx_op  = op;
      bus.tx_req = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.tx_req = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      vectors++; if (bus.tx_ready !== 1'b1) begin miscompares++; $display("FAIL rst_ready: got %b need 1", bus.tx_ready); end
      vectors++; if (bus.tx_busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b need 0", bus.tx_busy); end
      vectors++; if (bus.tx_done !== 1'b0) begin miscompares++; $display("FAIL rst_done: got %b need 0", bus.tx_done); end
      vectors++; if (bus.gmii_tx_en !== 1'b0) begin miscompares++; $display("FAIL rst_en: got %b need 0", bus.gmii_tx_en); end
      vectors++; if (bus.gmii_txd !== 8'h00) begin miscompares++; $display("FAIL rst_txd: got %h need 00", bus.gmii_txd); end
      rst_n = 1'b1;
   endtask

   task automatic test_request();
      int n, d;
      bus.local_ip = 32'hC0A8_010A;
      bus.des_ip   = 32'hC0A8_0170;
      issue(2'd0);
      vectors++; if (bus.gmii_tx_en !== 1'b1 || bus.gmii_txd !== 8'h55) begin miscompares++; $display("FAIL req_latency: en=%b txd=%h need en=1 txd=55", bus.gmii_tx_en, bus.gmii_txd); end
      vectors++; if (bus.tx_ready !== 1'b0 || bus.tx_busy !== 1'b1) begin miscompares++; $display("FAIL req_flags: ready=%b busy=%b need 0/1", bus.tx_ready, bus.tx_busy); end
      build_exp(BCAST, 16'h0001, 32'hC0A8_010A, 48'd0, 32'hC0A8_0170, 16'h0000);
      capture(n);
      vectors++; if (n !== FRAME_EN) begin miscompares++; $display("FAIL req_len: got %0d enable cycles need %0d", n, FRAME_EN); end
      d = first_diff();
      vectors++; if (d != -1) begin miscompares++; $display("FAIL req_bytes: byte %0d got %h need %h", d, got_q[d], exp_q[d]); end
      vectors++; if (residue() !== 32'hC704_DD7B) begin miscompares++; $display("FAIL req_fcs: residue %h need c704dd7b", residue()); end
      vectors++; if (bus.tx_done !== 1'b1) begin miscompares++; $display("FAIL req_done: got %b need 1", bus.tx_done); end
      @(negedge clk);
      vectors++; if (bus.tx_done !== 1'b0) begin miscompares++; $display("FAIL req_done_pulse: got %b need 0", bus.tx_done); end
   endtask

   task automatic test_reply();
      int n, d;
      bus.des_mac = 48'hAABB_CCDD_EE01;
      issue(2'd1);
      build_exp(48'hAABB_CCDD_EE01, 16'h0002, 32'hC0A8_010A, 48'hAABB_CCDD_EE01, 32'hC0A8_0170, 16'h0000);
      capture(n);
      vectors++; if (n !== FRAME_EN) begin miscompares++; $display("FAIL rep_len: got %0d need %0d", n, FRAME_EN); end
      d = first_diff();
      vectors++; if (d != -1) begin miscompares++; $display("FAIL rep_bytes: byte %0d got %h need %h", d, got_q[d], exp_q[d]); end
      vectors++; if (residue() !== 32'hC704_DD7B) begin miscompares++; $display("FAIL rep_fcs: residue %h need c704dd7b", residue()); end
   endtask

   task automatic test_gratuitous();
      int n, d;
      bus.local_ip = 32'h0A00_0005;
      issue(2'd2);
      build_exp(BCAST, 16'h0001, 32'h0A00_0005, 48'd0, 32'h0A00_0005, 16'h0000);
      capture(n);
      vectors++; if (n !== FRAME_EN) begin miscompares++; $display("FAIL grat_len: got %0d need %0d", n, FRAME_EN); end
      d = first_diff();
      vectors++; if (d != -1) begin miscompares++; $display("FAIL grat_bytes: byte %0d got %h need %h", d, got_q[d], exp_q[d]); end
      vectors++; if (residue() !== 32'hC704_DD7B) begin miscompares++; $display("FAIL grat_fcs: residue %h need c704dd7b", residue()); end
      bus.local_ip = 32'hC0A8_010A;
   endtask

   task automatic test_back_to_back();
      int n1, n2, d, t, gap, rdy_at, busy_bad, extra;
      bus.tx_op  = 2'd0;
      bus.des_ip = 32'hC0A8_0170;
      @(negedge clk);
      t = 0;
      while (!bus.tx_ready && t < 200) begin @(negedge clk); t++; end
      bus.tx_req = 1'b1;
      @(posedge clk);
      @(negedge clk);
      fork
         capture(n1);
         begin repeat (20) @(negedge clk); bus.des_ip = 32'hC0A8_0171; end
      join
      build_exp(BCAST, 16'h0001, 32'hC0A8_010A, 48'd0, 32'hC0A8_0170, 16'h0000);
      vectors++; if (n1 !== FRAME_EN) begin miscompares++; $display("FAIL b2b_len1: got %0d need %0d", n1, FRAME_EN); end
      d = first_diff();
      vectors++; if (d != -1) begin miscompares++; $display("FAIL b2b_bytes1: byte %0d got %h need %h", d, got_q[d], exp_q[d]); end
      gap = 0; rdy_at = 0; busy_bad = 0;
      while (!bus.gmii_tx_en && gap < 100) begin
         gap++;
         if (bus.tx_ready && rdy_at == 0) rdy_at = gap;
         if (gap < 12 && bus.tx_busy !== 1'b1) busy_bad++;
         @(negedge clk);
      end
      bus.tx_req = 1'b0;
      vectors++; if (gap !== 12) begin miscompares++; $display("FAIL b2b_gap: got %0d idle cycles need 12", gap); end
      vectors++; if (rdy_at !== 12) begin miscompares++; $display("FAIL b2b_ready: rose at gap cycle %0d need 12", rdy_at); end
      vectors++; if (busy_bad !== 0) begin miscompares++; $display("FAIL b2b_busy: %0d gap cycles with busy low, need 0", busy_bad); end
      capture(n2);
      build_exp(BCAST, 16'h0001, 32'hC0A8_010A, 48'd0, 32'hC0A8_0171, 16'h0000);
      vectors++; if (n2 !== FRAME_EN) begin miscompares++; $display("FAIL b2b_len2: got %0d need %0d", n2, FRAME_EN); end
      d = first_diff();
      vectors++; if (d != -1) begin miscompares++; $display("FAIL b2b_bytes2: byte %0d got %h need %h", d, got_q[d], exp_q[d]); end
      vectors++; if (residue() !== 32'hC704_DD7B) begin miscompares++; $display("FAIL b2b_fcs2: residue %h need c704dd7b", residue()); end
      extra = 0;
      repeat (40) begin @(negedge clk); if (bus.gmii_tx_en) extra++; end
      vectors++; if (extra !== 0) begin miscompares++; $display("FAIL b2b_queued: %0d extra enable cycles need 0", extra); end
      bus.des_ip = 32'hC0A8_0170;
   endtask

   task automatic test_reset_mid_frame();
      int n, d;
      issue(2'd0);
      repeat (30) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      vectors++; if (bus.gmii_tx_en !== 1'b0) begin miscompares++; $display("FAIL mid_rst_en: got %b need 0", bus.gmii_tx_en); end
      vectors++; if (bus.tx_ready !== 1'b1 || bus.tx_busy !== 1'b0) begin miscompares++; $display("FAIL mid_rst_flags: ready=%b busy=%b need 1/0", bus.tx_ready, bus.tx_busy); end
      @(negedge clk);
      rst_n = 1'b1;
      issue(2'd0);
      build_exp(BCAST, 16'h0001, 32'hC0A8_010A, 48'd0, 32'hC0A8_0170, 16'h0000);
      capture(n);
      vectors++; if (n !== FRAME_EN) begin miscompares++; $display("FAIL mid_len: got %0d need %0d", n, FRAME_EN); end
      d = first_diff();
      vectors++; if (d != -1) begin miscompares++; $display("FAIL mid_bytes: byte %0d got %h need %h", d, got_q[d], exp_q[d]); end
      vectors++; if (residue() !== 32'hC704_DD7B) begin miscompares++; $display("FAIL mid_fcs: residue %h need c704dd7b", residue()); end
   endtask

   task automatic test_reserved_op();
      int en_cnt, done_cnt;
      issue(2'd3);
      vectors++; if (bus.tx_done !== 1'b1) begin miscompares++; $display("FAIL rsv_done: got %b need 1", bus.tx_done); end
      vectors++; if (bus.tx_ready !== 1'b1 || bus.gmii_tx_en !== 1'b0) begin miscompares++; $display("FAIL rsv_flags: ready=%b en=%b need 1/0", bus.tx_ready, bus.gmii_tx_en); end
      en_cnt = 0; done_cnt = 0;
      repeat (20) begin
         @(negedge clk);
         if (bus.gmii_tx_en) en_cnt++;
         if (bus.tx_done) done_cnt++;
      end
      vectors++; if (en_cnt !== 0 || done_cnt !== 0) begin miscompares++; $display("FAIL rsv_quiet: en=%0d done=%0d cycles need 0/0", en_cnt, done_cnt); end
   endtask

`ifdef ARP_TX_VLAN_EN
   task automatic test_vlan();
      int n, d;
      bus.vlan_tci = 16'h0064;
      issue(2'd0);
      bus.vlan_tci = 16'h0FFF;
      build_exp(BCAST, 16'h0001, 32'hC0A8_010A, 48'd0, 32'hC0A8_0170, 16'h0064);
      capture(n);
      vectors++; if (n !== 76) begin miscompares++; $display("FAIL vlan_len: got %0d need 76", n); end
      d = first_diff();
      vectors++; if (d != -1) begin miscompares++; $display("FAIL vlan_bytes: byte %0d got %h need %h", d, got_q[d], exp_q[d]); end
      vectors++; if (residue() !== 32'hC704_DD7B) begin miscompares++; $display("FAIL vlan_fcs: residue %h need c704dd7b", residue()); end
   endtask
`endif

   initial begin
      bus.tx_req    = 1'b0;
      bus.tx_op     = 2'd0;
      bus.local_mac = MAC;
      bus.local_ip  = 32'hC0A8_010A;
      bus.des_mac   = 48'd0;
      bus.des_ip    = 32'hC0A8_0170;
`ifdef ARP_TX_VLAN_EN
      bus.vlan_tci  = 16'h0000;
`endif
      test_reset();
      test_request();
      test_reply();
      test_gratuitous();
      test_back_to_back();
      test_reset_mid_frame();
      test_reserved_op();
`ifdef ARP_TX_VLAN_EN
      test_vlan();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, need bench completion");
      $fatal(1, "watchdog");
   end

endmodule
